// File: rtl/axi4lite_regfile_slave.sv
// rtl/axi4lite_regfile_slave.sv - AXI4-Lite slave with byte-strobed register file, RO status slots and range errors
//
// Ports:
//   ACLK, ARESETn                      clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY             write address channel
//   WDATA/WSTRB/WVALID/WREADY          write data channel
//   BRESP/BVALID/BREADY                write response channel
//   ARADDR/ARVALID/ARREADY             read address channel
//   RDATA/RRESP/RVALID/RREADY          read data channel
//   reg_out                            flat register contents, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   status_in                          values returned by reads of read-only slots
//   reg_wr_pulse                       one-cycle pulse per register on a committed write

module axi4lite_regfile_slave #(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 ADDR_WIDTH = 8,
    parameter int                 NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}}
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFF_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_t;

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Write capture: each channel is held independently until its partner arrives
    logic              r_aw_held;
    logic              r_w_held;
    logic [IDX_W-1:0]  r_aw_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [1:0]        r_bresp;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_aw_idx;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]     w_wstrb;
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic                  w_wr_ok;
    logic [IDX_W-1:0]      w_ar_idx;
    logic                  w_rd_hit;
    logic [DATA_WIDTH-1:0] w_rd_val;

    // Byte-offset bits and status slices of RW slots carry no information here
    logic w_unused_bits;
    assign w_unused_bits = ^{AWADDR[OFF_W-1:0], ARADDR[OFF_W-1:0], status_in};

    assign w_awready = (r_wstate == W_IDLE) && !r_aw_held;
    assign w_wready  = (r_wstate == W_IDLE) && !r_w_held;
    assign w_aw_hs   = AWVALID && w_awready;
    assign w_w_hs    = WVALID && w_wready;
    assign w_ar_hs   = ARVALID && (r_rstate == R_IDLE);

    // A channel completing on this edge is used directly, so commit can coincide with the last handshake
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_aw_idx  = r_aw_held ? r_aw_idx : AWADDR[ADDR_WIDTH-1:OFF_W];
    assign w_wdata   = r_w_held  ? r_wdata  : WDATA;
    assign w_wstrb   = r_w_held  ? r_wstrb  : WSTRB;
    assign w_ar_idx  = ARADDR[ADDR_WIDTH-1:OFF_W];

    // One-hot write target; stays all-zero for out-of-range or read-only addresses
    always_comb begin
        w_wr_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_sel[i] = (w_aw_idx == IDX_W'(i)) && !RO_MASK[i];
        end
    end
    assign w_wr_ok = |w_wr_sel;

    always_comb begin
        w_rd_hit = 1'b0;
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_ar_idx == IDX_W'(i)) begin
                w_rd_hit = 1'b1;
                w_rd_val = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP: if (BREADY)   w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: if (ARVALID) w_rstate_nxt = R_RESP;
            R_RESP: if (RREADY)  w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= w_commit ? w_wr_sel : '0;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= AWADDR[ADDR_WIDTH-1:OFF_W];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= WDATA;
                    r_wstrb  <= WSTRB;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < STRB_W; k++) begin
                    if (w_wr_sel[i] && w_wstrb[k]) begin
                        r_regs[i][k*8 +: 8] <= w_wdata[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Read data is sampled from the pre-commit register value on a coincident write
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_val;
            r_rresp <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : r_regs[g];
    end

    assign AWREADY      = w_awready;
    assign WREADY       = w_wready;
    assign BVALID       = (r_wstate == W_RESP);
    assign BRESP        = r_bresp;
    assign ARREADY      = (r_rstate == R_IDLE);
    assign RVALID       = (r_rstate == R_RESP);
    assign RDATA        = r_rdata;
    assign RRESP        = r_rresp;
    assign reg_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// tb/tb_axi4lite_regfile_slave.sv - directed self-checking bench for axi4lite_regfile_slave

module tb_axi4lite_regfile_slave;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [7:0]   AWADDR = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [7:0]   ARADDR = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [511:0] reg_out;
    logic [511:0] status_in = '0;
    logic [15:0]  reg_wr_pulse;

    int n_vec = 0;
    int n_err = 0;

    axi4lite_regfile_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .NUM_REGS   (16),
        .RO_MASK    (16'h0008)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .AWADDR       (AWADDR),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .BRESP        (BRESP),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .ARADDR       (ARADDR),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .RDATA        (RDATA),
        .RRESP        (RRESP),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .reg_out      (reg_out),
        .status_in    (status_in),
        .reg_wr_pulse (reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic cyc();
        @(negedge ACLK);
    endtask

    task automatic b_ack();
        BREADY = 1'b1;
        cyc();
        BREADY = 1'b0;
    endtask

    task automatic r_ack();
        RREADY = 1'b1;
        cyc();
        RREADY = 1'b0;
    endtask

    // AW and W together, then response accepted
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        b_ack();
    endtask

    task automatic test_reset();
        n_vec++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL rst_awready: got %b want 1", AWREADY); end
        n_vec++; if (WREADY !== 1'b1) begin n_err++; $display("FAIL rst_wready: got %b want 1", WREADY); end
        n_vec++; if (ARREADY !== 1'b1) begin n_err++; $display("FAIL rst_arready: got %b want 1", ARREADY); end
        n_vec++; if (BVALID !== 1'b0 || RVALID !== 1'b0) begin n_err++; $display("FAIL rst_valids: got b=%b r=%b want 0 0", BVALID, RVALID); end
        n_vec++; if (BRESP !== 2'b00 || RRESP !== 2'b00) begin n_err++; $display("FAIL rst_resp: got b=%b r=%b want 00 00", BRESP, RRESP); end
        n_vec++; if (RDATA !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
        n_vec++; if (reg_out !== 512'h0) begin n_err++; $display("FAIL rst_reg_out: got %h want 0", reg_out); end
        n_vec++; if (reg_wr_pulse !== 16'h0) begin n_err++; $display("FAIL rst_pulse: got %h want 0", reg_wr_pulse); end
    endtask

    task automatic test_write_read();
        AWADDR = 8'h04; AWVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        n_vec++; if (BVALID !== 1'b1) begin n_err++; $display("FAIL wr_bvalid: got %b want 1", BVALID); end
        n_vec++; if (BRESP !== 2'b00) begin n_err++; $display("FAIL wr_bresp: got %b want 00", BRESP); end
        n_vec++; if (reg_out[32 +: 32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_reg1: got %h want deadbeef", reg_out[32 +: 32]); end
        n_vec++; if (reg_wr_pulse !== 16'h0002) begin n_err++; $display("FAIL wr_pulse: got %h want 0002", reg_wr_pulse); end
        n_vec++; if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin n_err++; $display("FAIL wr_ready_in_resp: got aw=%b w=%b want 0 0", AWREADY, WREADY); end
        b_ack();
        n_vec++; if (BVALID !== 1'b0) begin n_err++; $display("FAIL wr_bvalid_clear: got %b want 0", BVALID); end
        n_vec++; if (reg_wr_pulse !== 16'h0) begin n_err++; $display("FAIL wr_pulse_clear: got %h want 0", reg_wr_pulse); end
        ARADDR = 8'h04; ARVALID = 1'b1;
        cyc();
        ARVALID = 1'b0;
        n_vec++; if (RVALID !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b want 1", RVALID); end
        n_vec++; if (RDATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef", RDATA); end
        n_vec++; if (RRESP !== 2'b00) begin n_err++; $display("FAIL rd_rresp: got %b want 00", RRESP); end
        r_ack();
        n_vec++; if (RVALID !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_clear: got %b want 0", RVALID); end
    endtask

    task automatic test_w_before_aw();
        wr(8'h08, 32'hAABBCCDD, 4'hF);
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
        cyc();
        WVALID = 1'b0;
        n_vec++; if (WREADY !== 1'b0) begin n_err++; $display("FAIL wfirst_wready: got %b want 0", WREADY); end
        n_vec++; if (AWREADY !== 1'b1) begin n_err++; $display("FAIL wfirst_awready: got %b want 1", AWREADY); end
        cyc();
        cyc();
        n_vec++; if (BVALID !== 1'b0) begin n_err++; $display("FAIL wfirst_no_bvalid: got %b want 0", BVALID); end
        n_vec++; if (reg_out[64 +: 32] !== 32'hAABBCCDD) begin n_err++; $display("FAIL wfirst_reg2_early: got %h want aabbccdd", reg_out[64 +: 32]); end
        AWADDR = 8'h08; AWVALID = 1'b1;
        cyc();
        AWVALID = 1'b0;
        n_vec++; if (reg_out[64 +: 32] !== 32'hAA22CC44) begin n_err++; $display("FAIL wfirst_reg2: got %h want aa22cc44", reg_out[64 +: 32]); end
        n_vec++; if (BVALID !== 1'b1 || BRESP !== 2'b00) begin n_err++; $display("FAIL wfirst_b: got v=%b r=%b want 1 00", BVALID, BRESP); end
        n_vec++; if (reg_wr_pulse !== 16'h0004) begin n_err++; $display("FAIL wfirst_pulse: got %h want 0004", reg_wr_pulse); end
        b_ack();
    endtask

    task automatic test_out_of_range();
        AWADDR = 8'h40; AWVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        n_vec++; if (BVALID !== 1'b1 || BRESP !== 2'b10) begin n_err++; $display("FAIL oor_b: got v=%b r=%b want 1 10", BVALID, BRESP); end
        n_vec++; if (reg_wr_pulse !== 16'h0) begin n_err++; $display("FAIL oor_pulse: got %h want 0", reg_wr_pulse); end
        b_ack();
        ARADDR = 8'h40; ARVALID = 1'b1;
        cyc();
        ARVALID = 1'b0;
        n_vec++; if (RDATA !== 32'h0 || RRESP !== 2'b10) begin n_err++; $display("FAIL oor_r: got d=%h r=%b want 0 10", RDATA, RRESP); end
        r_ack();
    endtask

    task automatic test_ro();
        status_in[96 +: 32] = 32'h5A5A5A5A;
        AWADDR = 8'h0C; AWVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        n_vec++; if (BRESP !== 2'b10) begin n_err++; $display("FAIL ro_bresp: got %b want 10", BRESP); end
        n_vec++; if (reg_out[96 +: 32] !== 32'h0) begin n_err++; $display("FAIL ro_reg_out: got %h want 0", reg_out[96 +: 32]); end
        n_vec++; if (reg_wr_pulse !== 16'h0) begin n_err++; $display("FAIL ro_pulse: got %h want 0", reg_wr_pulse); end
        b_ack();
        ARADDR = 8'h0C; ARVALID = 1'b1;
        cyc();
        ARVALID = 1'b0;
        n_vec++; if (RDATA !== 32'h5A5A5A5A || RRESP !== 2'b00) begin n_err++; $display("FAIL ro_r: got d=%h r=%b want 5a5a5a5a 00", RDATA, RRESP); end
        r_ack();
    endtask

    task automatic test_wstrb_zero();
        AWADDR = 8'h08; AWVALID = 1'b1; WDATA = 32'hFFFFFFFF; WSTRB = 4'h0; WVALID = 1'b1;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        n_vec++; if (reg_wr_pulse !== 16'h0004) begin n_err++; $display("FAIL strb0_pulse: got %h want 0004", reg_wr_pulse); end
        n_vec++; if (reg_out[64 +: 32] !== 32'hAA22CC44 || BRESP !== 2'b00) begin n_err++; $display("FAIL strb0_reg2: got %h r=%b want aa22cc44 00", reg_out[64 +: 32], BRESP); end
        b_ack();
    endtask

    task automatic test_backpressure();
        AWADDR = 8'h04; AWVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF; WVALID = 1'b1;
        ARADDR = 8'h08; ARVALID = 1'b1;
        cyc();
        // Keep new requests offered; none may be taken while responses are pending
        AWADDR = 8'h00; WDATA = 32'hFFFFFFFF; ARADDR = 8'h04;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (BVALID !== 1'b1 || RVALID !== 1'b1) begin n_err++; $display("FAIL bp_valids[%0d]: got b=%b r=%b want 1 1", i, BVALID, RVALID); end
            n_vec++; if (BRESP !== 2'b00 || RDATA !== 32'hAA22CC44) begin n_err++; $display("FAIL bp_stable[%0d]: got br=%b d=%h want 00 aa22cc44", i, BRESP, RDATA); end
            n_vec++; if (AWREADY !== 1'b0 || WREADY !== 1'b0 || ARREADY !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got aw=%b w=%b ar=%b want 0 0 0", i, AWREADY, WREADY, ARREADY); end
            cyc();
        end
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        r_ack();
        n_vec++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin n_err++; $display("FAIL bp_rdone: got rv=%b ar=%b want 0 1", RVALID, ARREADY); end
        n_vec++; if (BVALID !== 1'b1 || AWREADY !== 1'b0) begin n_err++; $display("FAIL bp_bstill: got bv=%b aw=%b want 1 0", BVALID, AWREADY); end
        b_ack();
        n_vec++; if (reg_out[31:0] !== 32'h0 || reg_out[32 +: 32] !== 32'h0BADF00D) begin n_err++; $display("FAIL bp_regs: got r0=%h r1=%h want 0 0badf00d", reg_out[31:0], reg_out[32 +: 32]); end
    endtask

    task automatic test_same_edge();
        AWADDR = 8'h04; AWVALID = 1'b1; WDATA = 32'h13579BDF; WSTRB = 4'hF; WVALID = 1'b1;
        ARADDR = 8'h04; ARVALID = 1'b1;
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        n_vec++; if (RDATA !== 32'h0BADF00D) begin n_err++; $display("FAIL same_rdata: got %h want 0badf00d", RDATA); end
        n_vec++; if (reg_out[32 +: 32] !== 32'h13579BDF) begin n_err++; $display("FAIL same_reg1: got %h want 13579bdf", reg_out[32 +: 32]); end
        BREADY = 1'b1; RREADY = 1'b1;
        cyc();
        BREADY = 1'b0; RREADY = 1'b0;
        n_vec++; if (BVALID !== 1'b0 || RVALID !== 1'b0) begin n_err++; $display("FAIL same_done: got b=%b r=%b want 0 0", BVALID, RVALID); end
    endtask

    task automatic test_reset_mid();
        AWADDR = 8'h08; AWVALID = 1'b1;
        ARADDR = 8'h04; ARVALID = 1'b1;
        cyc();
        AWVALID = 1'b0; ARVALID = 1'b0;
        n_vec++; if (AWREADY !== 1'b0 || WREADY !== 1'b1 || RVALID !== 1'b1) begin n_err++; $display("FAIL mid_half: got aw=%b w=%b rv=%b want 0 1 1", AWREADY, WREADY, RVALID); end
        #1 ARESETn = 1'b0;
        #1;
        n_vec++; if (AWREADY !== 1'b1 || WREADY !== 1'b1 || ARREADY !== 1'b1) begin n_err++; $display("FAIL mid_ready: got aw=%b w=%b ar=%b want 1 1 1", AWREADY, WREADY, ARREADY); end
        n_vec++; if (RVALID !== 1'b0 || BVALID !== 1'b0 || RDATA !== 32'h0 || RRESP !== 2'b00) begin n_err++; $display("FAIL mid_outs: got rv=%b bv=%b d=%h r=%b want 0 0 0 00", RVALID, BVALID, RDATA, RRESP); end
        n_vec++; if (reg_out !== 512'h0 || reg_wr_pulse !== 16'h0) begin n_err++; $display("FAIL mid_regs: got %h p=%h want 0 0", reg_out, reg_wr_pulse); end
        cyc();
        ARESETn = 1'b1;
        cyc();
        WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
        cyc();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (BVALID !== 1'b0 || reg_wr_pulse !== 16'h0) begin n_err++; $display("FAIL mid_no_b[%0d]: got bv=%b p=%h want 0 0", i, BVALID, reg_wr_pulse); end
            cyc();
        end
        n_vec++; if (WREADY !== 1'b0 || reg_out[64 +: 32] !== 32'h0) begin n_err++; $display("FAIL mid_wheld: got w=%b r2=%h want 0 0", WREADY, reg_out[64 +: 32]); end
    endtask

    initial begin
        repeat (3) cyc();
        ARESETn = 1'b1;
        test_reset();
        test_write_read();
        test_w_before_aw();
        test_out_of_range();
        test_ro();
        test_wstrb_zero();
        test_backpressure();
        test_same_edge();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4lite_regfile_slave.md
# axi4lite_regfile_slave

Parametrised AXI4-Lite slave with an internal register file, byte-strobed writes, address-range error responses and per-register read-only/status mapping. It replaces the fixed read/write FSM pair with a single block whose data width, address width and register count are set per instance. It sits between an AXI4-Lite master and the team's configuration and status logic, exposing the register contents as a flat output bus.

## Interface
- DATA_WIDTH, 32, data bus width; 32 or 64 only.
- ADDR_WIDTH, 8, byte address width.
- NUM_REGS, 16, number of DATA_WIDTH registers; 1 to 2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RO_MASK, {NUM_REGS{1'b0}}, bit i set makes register i read-only and sourced from status_in.
- ACLK  in  1  single clock; all logic on its rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWADDR  in  ADDR_WIDTH; AWVALID  in  1; AWREADY  out  1  (write address channel).
- WDATA  in  DATA_WIDTH; WSTRB  in  DATA_WIDTH/8; WVALID  in  1; WREADY  out  1  (write data channel).
- BRESP  out  2; BVALID  out  1; BREADY  in  1  (write response channel).
- ARADDR  in  ADDR_WIDTH; ARVALID  in  1; ARREADY  out  1  (read address channel).
- RDATA  out  DATA_WIDTH; RRESP  out  2; RVALID  out  1; RREADY  in  1  (read data channel).
- reg_out  out  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]; RO slots drive 0.
- status_in  in  NUM_REGS*DATA_WIDTH  values returned for RO registers; ignored for RW slots.
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on register i when a write is committed to it.

## Operation
- Decode: index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored. index >= NUM_REGS is out of range.
- Write FSM states W_IDLE, W_RESP. In W_IDLE, AW and W are accepted independently in either order: AWREADY = !aw_held, WREADY = !w_held. Captured address/data are held until both are present.
- On the edge where both AW and W are held (either channel may complete on that same edge): commit, clear holds, BVALID <= 1, go to W_RESP.
- Commit, in range, RW register: byte lane k is written iff WSTRB[k]; BRESP = OKAY (2'b00); reg_wr_pulse[index] = 1 for one cycle, even when WSTRB = 0.
- Commit, out of range or RO register: no change, no pulse, BRESP = SLVERR (2'b10).
- W_RESP: AWREADY = WREADY = 0; BVALID is held with BRESP stable until BREADY; on BVALID && BREADY go to W_IDLE.
- Read FSM states R_IDLE, R_RESP. ARREADY = 1 only in R_IDLE. On AR handshake, RDATA/RRESP are registered, RVALID <= 1, go to R_RESP.
- RDATA: register value for RW; status_in slice sampled at the handshake edge for RO; 0 with RRESP = SLVERR when out of range.
- R_RESP: RDATA/RRESP are held stable until RREADY; on RVALID && RREADY go to R_IDLE.
- Read and write paths are fully independent and may be active in the same cycle.

## Timing
- Reset (ARESETn low, asynchronous): all registers 0; BVALID = RVALID = 0; BRESP = RRESP = 2'b00; RDATA = 0; reg_wr_pulse = 0; FSMs in IDLE, so AWREADY = WREADY = ARREADY = 1.
- Reset asserted mid-transaction drops that transaction silently; no response is issued after release.
- Write latency: BVALID is high the cycle after the last of AW/W handshakes. reg_out updates on the same edge. reg_wr_pulse is high for that one cycle.
- Read latency: RVALID is high the cycle after the AR handshake. Peak throughput is one read per 2 cycles and one write per 2 cycles, given a ready master.
- Same-edge AR handshake and write commit to the same register: the read returns the pre-write value.
- Back-pressure: BVALID and RVALID never drop without a handshake. No new AW/W/AR is accepted while the corresponding response is pending.

## Test plan
- Reset, then AW = 0x04 and W = 0xDEADBEEF with WSTRB = 4'hF in the same cycle -> next cycle BVALID = 1, BRESP = 0, reg 1 = 0xDEADBEEF, reg_wr_pulse = 16'h0002; a read of 0x04 then returns 0xDEADBEEF with RRESP = 0.
- W arrives 3 cycles before AW (addr 0x08, data 0x11223344, WSTRB = 4'b0101) on a reg 2 preloaded with 0xAABBCCDD -> WREADY = 0 after the W handshake; reg 2 = 0xAA22CC44 one cycle after the AW handshake.
- With NUM_REGS = 16, write and read of address 0x40 -> BRESP = 2'b10, no reg_wr_pulse; RDATA = 0, RRESP = 2'b10.
- With RO_MASK = 16'h0008 and status_in slot 3 = 0x5A5A5A5A -> a write to 0x0C returns SLVERR and leaves reg_out slot 3 at 0; a read of 0x0C returns 0x5A5A5A5A with OKAY.
- Hold BREADY and RREADY low for 5 cycles with both responses pending -> BVALID, RVALID, BRESP, RDATA stable and AWREADY = WREADY = ARREADY = 0; a single-cycle RREADY completes the read, and ARREADY = 1 the next cycle.
- Pull ARESETn low while a write is half-captured (AW only) -> all outputs return to their reset values immediately; after release, W alone produces no BVALID.
